mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
Parametrised multi-cycle multiply/divide unit for the RV32M/RV64M extension; the successor to the ALU decoder path for funct7 = 0000001 R-type ops.
- Decodes funct3 into one of eight M operations.
- Runs an iterative shift-add multiplier or restoring divider, with valid/ready handshakes on both sides.
- Sits beside the ALU in the execute stage; the controller stalls the datapath while in_ready is low.

Parameters:
XLEN, 32, operand/result width (32 or 64)
FAST_MUL, 0, 0 = iterative multiply (XLEN iterations); 1 = single-cycle combinational multiply
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
flush  in  1  kill in-flight op, return to IDLE
in_valid  in  1  operation request
in_ready  out  1  unit can accept a request
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
srcA  in  XLEN  rs1 operand
srcB  in  XLEN  rs2 operand
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  XLEN  operation result
busy  out  1  state != IDLE

Behaviour:
- Reset (reset == 0 at a rising edge) sets the following:
  - state = IDLE, counter = 0, accumulators = 0.
  - out_valid = 0, result = 0, busy = 0, in_ready = 1.
  - Reset mid-operation abandons the op; no result is produced.
- States are IDLE, MUL, DIV, DONE.
- in_ready = 1 only in IDLE. An op is accepted when in_valid & in_ready at a rising edge; funct3, srcA and srcB are registered at that edge.
- Transitions from IDLE on accept:
  - funct3[2] = 0 with FAST_MUL = 0: go to MUL, counter = XLEN.
  - funct3[2] = 0 with FAST_MUL = 1: compute the product and go directly to DONE.
  - funct3[2] = 1 with srcB == 0: divide-by-zero. Go to DONE with quotient = all ones and remainder = srcA.
  - DIV/REM with srcA == 1 << (XLEN-1) and srcB == all ones: signed overflow. Go to DONE with quotient = srcA and remainder = 0.
  - Any other divide: go to DIV, counter = XLEN.
- MUL: one multiplier bit per cycle, 2*XLEN accumulator.
  - Operands are converted to magnitudes per signedness: MUL/MULH treat A and B as signed; MULHSU treats A signed, B unsigned; MULHU treats both unsigned.
  - The product is negated at completion if the operand signs differ and the op is signed.
  - When counter reaches 1, go to DONE.
- DIV: restoring division, one quotient bit per cycle, on magnitudes.
  - Quotient sign = sA ^ sB (signed ops only).
  - Remainder sign = sign of dividend.
  - When counter reaches 1, go to DONE.
- Result selection, registered on entry to DONE:
  - MUL: product[XLEN-1:0].
  - MULH/MULHSU/MULHU: product[2*XLEN-1:XLEN].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - XLEN = 64 needs no W-variants; W ops are out of scope.
- DONE: out_valid = 1 and result is held stable until out_ready. On out_valid & out_ready, go to IDLE; in_ready rises the next cycle. There is no back-to-back accept in the DONE cycle.
- Latency from the accepting edge to the first cycle with out_valid high:
  - Iterative ops: XLEN+1 clocks.
  - Divide-by-zero, overflow, and FAST_MUL multiply: 1 clock.
- flush = 1 at an edge goes to IDLE from any state and clears out_valid. flush has priority over accept and completion; reset has priority over flush.
- funct3 is fully decoded; there is no X output for any encoding.
- busy = (state != IDLE).

Decomposition:
- Package mdu_pkg holds:
  - funct3 localparams MDU_MUL..MDU_REMU.
  - State encoding as a 2-bit enum: IDLE = 0, MUL = 1, DIV = 2, DONE = 3.
- The top level holds the FSM, handshake, sign handling and special-case detection.
- One sub-module, mdu_divider, is the unsigned restoring-division step datapath: remainder/quotient shift registers and subtract-compare, stepped by a start/step enable from the top.
- The multiply datapath stays in the top level.

Test Plan:
- MUL srcA = 7, srcB = 0xFFFFFFFD (XLEN = 32, FAST_MUL = 0) -> result 0xFFFFFFEB; out_valid first high 33 clocks after accept; in_ready low throughout.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 % 7 -> 2.
- Special cases, each with out_valid 1 clock after accept:
  - DIV 5 / 0 -> 0xFFFFFFFF.
  - REM 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- Backpressure: out_ready held low 5 cycles after out_valid -> result stable, in_ready = 0; in_valid asserted during DONE is not accepted; accept succeeds the cycle after the handshake.
- Interrupting an op: flush at iteration 10 of a DIV -> IDLE next cycle, no out_valid, next op (MUL 3 x 4 = 12) correct. reset = 0 mid-MUL -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M/RV64M multiply/divide unit.
package mdu_pkg;

  // funct3 encodings of the M-extension R-type operations
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  // rs1 is signed for MUL/MULH/MULHSU and for DIV/REM
  function automatic logic op_a_signed(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
  endfunction

  // rs2 is signed for MUL/MULH and for DIV/REM
  function automatic logic op_b_signed(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : ~f3[1];
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Unsigned restoring-division datapath: one quotient bit per step.
// Exposes next-state values so the top can capture the final result
// on the same edge as the last step.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Shift next dividend bit into the partial remainder, trial-subtract, restore on borrow
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      rem_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
    end
  end

  assign quo_next = quo_d;
  assign rem_next = rem_d;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit: FSM, handshakes, sign handling,
// special-case detection and the iterative shift-add multiplier.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;     // negate product / quotient
  logic              rneg_q, rneg_d;   // negate remainder
  logic [2*XLEN-1:0] prod_q, prod_d;   // {partial product, remaining multiplier}
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [2*XLEN-1:0] fast_prod, fast_fix;
  logic [XLEN:0]     add_sum;
  logic [2*XLEN-1:0] prod_step, prod_fix;
  logic              div_start, div_step;
  logic [XLEN-1:0]   div_quo_next, div_rem_next, quo_fix, rem_fix;

  // Operand magnitudes and special-case detection for the incoming request
  always_comb begin
    sign_a    = op_a_signed(funct3) & srcA[XLEN-1];
    sign_b    = op_b_signed(funct3) & srcB[XLEN-1];
    mag_a     = sign_a ? -srcA : srcA;
    mag_b     = sign_b ? -srcB : srcB;
    div_zero  = funct3[2] & (srcB == '0);
    div_ovf   = funct3[2] & ~funct3[0] & (srcA == MIN_INT) & (srcB == '1);
    fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    fast_fix  = (sign_a ^ sign_b) ? -fast_prod : fast_prod;
  end

  // One shift-add multiply step plus sign fix-up of the stepped product
  always_comb begin
    add_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mcand_q : {XLEN{1'b0}})};
    prod_step = {add_sum, prod_q[XLEN-1:1]};
    prod_fix  = neg_q ? -prod_step : prod_step;
    quo_fix   = neg_q ? -div_quo_next : div_quo_next;
    rem_fix   = rneg_q ? -div_rem_next : div_rem_next;
  end

  mdu_divider #(.XLEN(XLEN)) u_divider (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo_next (div_quo_next),
    .rem_next (div_rem_next)
  );

  // Next-state logic: accept, iterate, select result, hand off
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    result_d  = result_q;
    div_start = 1'b0;
    div_step  = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d   = funct3;
            neg_d  = sign_a ^ sign_b;
            rneg_d = sign_a;
            cnt_d  = CNT_INIT;
            if (!funct3[2]) begin
              if (FAST_MUL != 0) begin
                result_d = (funct3 == MDU_MUL) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
                cnt_d    = '0;
                state_d  = DONE;
              end else begin
                prod_d  = {{XLEN{1'b0}}, mag_b};
                mcand_d = mag_a;
                state_d = MUL;
              end
            end else if (div_zero) begin
              // quotient all ones, remainder = dividend
              result_d = funct3[1] ? srcA : {XLEN{1'b1}};
              cnt_d    = '0;
              state_d  = DONE;
            end else if (div_ovf) begin
              // quotient = dividend, remainder = 0
              result_d = funct3[1] ? {XLEN{1'b0}} : srcA;
              cnt_d    = '0;
              state_d  = DONE;
            end else begin
              div_start = 1'b1;
              state_d   = DIV;
            end
          end
        end
        MUL: begin
          prod_d = prod_step;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == 1) begin
            result_d = (op_q == MDU_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
            state_d  = DONE;
          end
        end
        DIV: begin
          div_step = 1'b1;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == 1) begin
            result_d = op_q[1] ? rem_fix : quo_fix;
            state_d  = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq (XLEN = 32, iterative multiply).
module tb_mdu_seq;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_seq #(.XLEN(32), .FAST_MUL(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .srcA      (srcA),
    .srcB      (srcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // Issue one op, wait (bounded) for out_valid, capture result, then hand it off.
  // lat = clocks from accept edge to first cycle with out_valid, -1 on timeout.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output logic rdy_seen);
    funct3 = f; srcA = a; srcB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = in_ready;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid && in_ready) rdy_seen = 1'b1;
    end
    if (!out_valid) lat = -1;
    res = result;
    $display("op f3=%0d a=%08h b=%08h -> result=%08h latency=%0d", f, a, b, res, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b result=%08h busy=%b in_ready=%b required 0/00000000/0/1",
               out_valid, result, busy, in_ready);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [2:0]  f [4]   = '{MDU_MUL, MDU_MULH, MDU_MULHU, MDU_MULHSU};
    logic [31:0] a [4]   = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] b [4]   = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [31:0] res;
    int lat;
    logic rdy;
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], b[i], res, lat, rdy);
      checks++;
      if (res !== exp[i]) begin
        errors++;
        $display("FAIL mul_result[%0d]: got %08h expected %08h", i, res, exp[i]);
      end
      if (i == 0) begin
        checks++;
        if (lat != 33) begin
          errors++;
          $display("FAIL mul_latency: got %0d expected 33", lat);
        end
        checks++;
        if (rdy !== 1'b0) begin
          errors++;
          $display("FAIL mul_in_ready_low: in_ready seen high=%b expected 0", rdy);
        end
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f [4]   = '{MDU_DIV, MDU_REM, MDU_DIVU, MDU_REMU};
    logic [31:0] a [4]   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] b [4]   = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    logic [31:0] res;
    int lat;
    logic rdy;
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], b[i], res, lat, rdy);
      checks++;
      if (res !== exp[i]) begin
        errors++;
        $display("FAIL div_result[%0d]: got %08h expected %08h", i, res, exp[i]);
      end
      checks++;
      if (lat != 33) begin
        errors++;
        $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f [4]   = '{MDU_DIV, MDU_REM, MDU_DIV, MDU_REM};
    logic [31:0] a [4]   = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] b [4]   = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    logic [31:0] res;
    int lat;
    logic rdy;
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], b[i], res, lat, rdy);
      checks++;
      if (res !== exp[i]) begin
        errors++;
        $display("FAIL special_result[%0d]: got %08h expected %08h", i, res, exp[i]);
      end
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL special_latency[%0d]: got %0d expected 1", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    funct3 = MDU_DIVU; srcA = 32'd100; srcB = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout: out_valid=%b expected 1 within 100 cycles", out_valid);
    end
    // new request offered while the result waits: must not be taken
    funct3 = MDU_DIVU; srcA = 32'd5; srcB = 32'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd14 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b result=%08h in_ready=%b required 1/0000000e/0",
                 i, out_valid, result, in_ready);
      end
    end
    $display("op f3=%0d a=%08h b=%08h -> result=%08h held 5 cycles", MDU_DIVU, 32'd100, 32'd7, result);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_accept_in_done: in_ready=%b busy=%b out_valid=%b required 1/0/0",
               in_ready, busy, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL bp_accept_after: out_valid=%b result=%08h required 1/ffffffff", out_valid, result);
    end
    $display("op f3=%0d a=%08h b=%08h -> result=%08h after handshake", MDU_DIVU, 32'd5, 32'd0, result);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic seen;
    logic [31:0] res;
    int lat;
    logic rdy;
    funct3 = MDU_DIV; srcA = 32'd1000; srcB = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    $display("op f3=%0d a=%08h b=%08h -> flushed at iteration 10", MDU_DIV, 32'd1000, 32'd3);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: busy=%b out_valid=%b in_ready=%b required 0/0/1", busy, out_valid, in_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_result: out_valid seen=%b expected 0", seen);
    end
    do_op(MDU_MUL, 32'd3, 32'd4, res, lat, rdy);
    checks++;
    if (res !== 32'd12) begin
      errors++;
      $display("FAIL flush_next_op: got %08h expected 0000000c", res);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat;
    logic rdy;
    funct3 = MDU_MUL; srcA = 32'd5; srcB = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    $display("op f3=%0d a=%08h b=%08h -> reset mid-operation", MDU_MUL, 32'd5, 32'd6);
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b result=%08h busy=%b in_ready=%b required 0/00000000/0/1",
               out_valid, result, busy, in_ready);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    do_op(MDU_REMU, 32'd100, 32'd7, res, lat, rdy);
    checks++;
    if (res !== 32'd2) begin
      errors++;
      $display("FAIL reset_recover: got %08h expected 00000002", res);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
